// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and line-level constants.
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Show-ahead FIFO read port between the transmit controller (master) and the FIFO (slave).
interface uart_tx_ctrl_if;
  import uart_pkg::*;

  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_q;
  logic                      fifo_rdreq;

  modport master (input fifo_empty, input fifo_q, output fifo_rdreq);
  modport slave  (output fifo_empty, output fifo_q, input fifo_rdreq);

endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; tick marks the last cycle of each bit period.
module uart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             load,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] count_reg;
  logic [DIV_W-1:0] reload;

  // Periods of 0 and 1 both collapse to a one-cycle bit.
  assign reload = (period > DIV_W'(1)) ? period - DIV_W'(1) : '0;
  assign tick   = (count_reg == '0);

  always_ff @(posedge clock) begin
    if (sclr) begin
      count_reg <= '0;
    end else if (load || tick) begin
      count_reg <= reload;
    end else begin
      count_reg <= count_reg - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops bytes from a show-ahead FIFO and serialises
// start, 8 data bits LSB first, optional parity and 1 or 2 stop bits on txd.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic               clock,
  input  logic               sclr,
  input  logic               en,
  input  logic [DIV_W-1:0]   baud_div,
  input  logic               parity_en,
  input  logic               parity_odd,
  input  logic               stop2,
  uart_tx_ctrl_if.master     fifo,
  output logic               txd,
  output logic               busy,
  output logic               frame_done
);

  tx_state_t                 state_reg;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [2:0]                bit_cnt_reg;
  logic                      par_reg;
  logic [DIV_W-1:0]          div_reg;
  logic                      par_en_reg;
  logic                      par_odd_reg;
  logic                      stop2_reg;
  logic                      txd_reg;

  logic                      tick;
  logic                      last_stop;
  logic                      launch;
  logic [DIV_W-1:0]          period;

  assign last_stop = (state_reg == STOP) && tick && (!stop2_reg || bit_cnt_reg[0]);

  // A new frame may start from IDLE or in the final stop cycle, giving gapless frames.
  assign launch = !sclr && en && !fifo.fifo_empty && ((state_reg == IDLE) || last_stop);

  assign fifo.fifo_rdreq = launch;
  assign frame_done      = last_stop && !sclr;
  assign busy            = (state_reg != IDLE) && !sclr;
  assign txd             = txd_reg;

  // The launching cycle loads the live divider; afterwards only the latched copy counts.
  assign period = launch ? baud_div : div_reg;

  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud_cnt (
    .clock  (clock),
    .sclr   (sclr),
    .load   (launch),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      par_reg     <= 1'b0;
      div_reg     <= '0;
      par_en_reg  <= 1'b0;
      par_odd_reg <= 1'b0;
      stop2_reg   <= 1'b0;
      txd_reg     <= UART_STOP_LVL;
    end else if (launch) begin
      state_reg   <= START;
      shift_reg   <= fifo.fifo_q;
      bit_cnt_reg <= '0;
      div_reg     <= baud_div;
      par_en_reg  <= parity_en;
      par_odd_reg <= parity_odd;
      stop2_reg   <= stop2;
      txd_reg     <= UART_START_LVL;
    end else begin
      case (state_reg)
        IDLE: begin
          txd_reg <= UART_STOP_LVL;
        end
        START: begin
          if (tick) begin
            state_reg   <= DATA;
            txd_reg     <= shift_reg[0];
            par_reg     <= shift_reg[0] ^ par_odd_reg;
            bit_cnt_reg <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt_reg == 3'(UART_DATA_BITS - 1)) begin
              bit_cnt_reg <= '0;
              if (par_en_reg) begin
                state_reg <= PARITY;
                txd_reg   <= par_reg;
              end else begin
                state_reg <= STOP;
                txd_reg   <= UART_STOP_LVL;
              end
            end else begin
              // par_reg accumulates each bit as it is put on the line.
              shift_reg   <= shift_reg >> 1;
              txd_reg     <= shift_reg[1];
              par_reg     <= par_reg ^ shift_reg[1];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state_reg   <= STOP;
            txd_reg     <= UART_STOP_LVL;
            bit_cnt_reg <= '0;
          end
        end
        STOP: begin
          if (tick) begin
            if (last_stop) begin
              state_reg <= IDLE;
              txd_reg   <= UART_STOP_LVL;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          txd_reg   <= UART_STOP_LVL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: FIFO model, frame scoreboard and serial-line monitor.
module tb_uart_tx_ctrl;

  typedef struct {
    logic [47:0] vec;
    int          len;
    logic [7:0]  data;
  } frame_t;

  logic        clock;
  logic        sclr;
  logic        en;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        stop2;
  logic        txd;
  logic        busy;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int pop_cnt = 0;

  logic [7:0] fq[$];
  logic [7:0] pend[$];
  frame_t     exp_q[$];

  uart_tx_ctrl_if bus();

  uart_tx_ctrl #(.DIV_W(16)) dut (
    .clock      (clock),
    .sclr       (sclr),
    .en         (en),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .fifo       (bus),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line waveform, one entry per clock cycle starting at the first start-bit cycle.
  function automatic frame_t build_frame(input logic [7:0] d, input int p,
                                         input bit pe, input bit po, input bit s2);
    frame_t      f;
    logic [11:0] bits;
    int          nb;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 10;
    if (pe) begin
      bits[9] = (^d) ^ po;
      nb = 11;
    end
    if (s2) nb++;
    f.vec  = '0;
    f.len  = nb * p;
    f.data = d;
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < p; k++)
        f.vec[b*p + k] = bits[b];
    return f;
  endfunction

  task automatic push(input logic [7:0] d);
    int p;
    p = (baud_div < 16'd2) ? 1 : int'(baud_div);
    pend.push_back(d);
    exp_q.push_back(build_frame(d, p, parity_en, parity_odd, stop2));
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rdreq(input int max);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.fifo_rdreq !== 1'b1 && n < max);
    check("rdreq_wait", bus.fifo_rdreq, 1);
  endtask

  task automatic wait_idle(input int max, input bit need_empty);
    int n;
    bit done;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      done = (busy === 1'b0) && (!need_empty || bus.fifo_empty === 1'b1);
    end while (!done && n < max);
    check("idle_wait", done, 1);
  endtask

  // Show-ahead FIFO model; outputs change with NBAs so the DUT captures pre-edge data.
  always @(posedge clock) begin
    if (bus.fifo_rdreq === 1'b1 && fq.size() > 0) begin
      void'(fq.pop_front());
      pop_cnt++;
    end
    while (pend.size() > 0) fq.push_back(pend.pop_front());
    bus.fifo_empty <= (fq.size() == 0);
    bus.fifo_q     <= (fq.size() > 0) ? fq[0] : 8'h00;
  end

  always @(negedge clock) begin
    if (bus.fifo_rdreq === 1'b1 && bus.fifo_empty === 1'b1)
      check("rdreq_while_empty", bus.fifo_rdreq, 0);
  end

  // Line monitor: captures each frame cycle by cycle and compares it with the scoreboard head.
  initial begin : monitor
    frame_t      f;
    logic [47:0] samp;
    logic [47:0] fdv;
    logic [47:0] fde;
    bit          aborted;
    forever begin
      @(negedge clock);
      if (sclr !== 1'b0 || txd !== 1'b0) continue;
      check("frame_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() == 0) continue;
      f       = exp_q[0];
      samp    = '0;
      fdv     = '0;
      aborted = 1'b0;
      for (int c = 0; c < f.len; c++) begin
        if (c > 0) @(negedge clock);
        if (sclr === 1'b1) begin
          aborted = 1'b1;
          break;
        end
        samp[c] = txd;
        fdv[c]  = frame_done;
      end
      void'(exp_q.pop_front());
      if (!aborted) begin
        fde = '0;
        fde[f.len-1] = 1'b1;
        $display("[TB] frame 0x%02h len %0d line 0x%012h done 0x%012h", f.data, f.len, samp, fdv);
        check($sformatf("frame_bits_%02h", f.data), samp, f.vec);
        check($sformatf("frame_done_pos_%02h", f.data), fdv, fde);
      end else begin
        $display("[TB] frame 0x%02h aborted by reset", f.data);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int pops;
    int busy_cnt;
    bit any_pop;

    sclr       = 1'b1;
    en         = 1'b1;
    baud_div   = 16'd4;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;

    // Reset with data waiting and enable high: nothing may move.
    push(8'hA5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("rst_txd", txd, 1);
      check("rst_busy", busy, 0);
      check("rst_rdreq", bus.fifo_rdreq, 0);
    end
    cyc();
    sclr = 1'b0;

    // Single byte 0xA5, P=4, no parity, one stop bit.
    @(negedge clock);
    check("first_pop", bus.fifo_rdreq, 1);
    @(negedge clock);
    check("start_latency_txd", txd, 0);
    check("start_latency_busy", busy, 1);
    wait_idle(100, 1'b1);
    check("single_pop_count", pop_cnt, 1);

    // 0x07 with even parity and two stop bits at P=1: parity bit is 1.
    cyc();
    baud_div   = 16'd1;
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    stop2      = 1'b1;
    push(8'h07);
    wait_rdreq(20);
    repeat (10) @(negedge clock);
    check("even_parity_bit", txd, 1);
    wait_idle(50, 1'b1);

    // Same byte with odd parity: parity bit is 0.
    cyc();
    parity_odd = 1'b1;
    push(8'h07);
    wait_rdreq(20);
    repeat (10) @(negedge clock);
    check("odd_parity_bit", txd, 0);
    wait_idle(50, 1'b1);

    // Back-to-back drain of a full FIFO at P=2.
    cyc();
    en         = 1'b0;
    baud_div   = 16'd2;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
    cyc();
    cyc();
    en       = 1'b1;
    pops     = 0;
    busy_cnt = 0;
    for (int i = 0; i < 330; i++) begin
      @(negedge clock);
      if (bus.fifo_rdreq === 1'b1) begin
        pops++;
        if (pops > 1) check("b2b_pop_with_done", frame_done, 1);
      end
      if (busy === 1'b1) busy_cnt++;
    end
    check("b2b_pops", pops, 16);
    check("b2b_busy_cycles", busy_cnt, 320);
    check("b2b_fifo_empty", bus.fifo_empty, 1);

    // Enable dropped in the middle of frame 1 with 3 bytes queued.
    cyc();
    en = 1'b0;
    push(8'h3C);
    push(8'h81);
    push(8'h5A);
    cyc();
    cyc();
    en = 1'b1;
    wait_rdreq(10);
    repeat (5) cyc();
    en = 1'b0;
    wait_idle(100, 1'b0);
    any_pop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.fifo_rdreq === 1'b1) any_pop = 1'b1;
    end
    check("en_low_no_pop", any_pop, 0);
    check("en_low_bytes_left", fq.size(), 2);
    cyc();
    en = 1'b1;
    @(negedge clock);
    check("en_resume_pop", bus.fifo_rdreq, 1);
    @(negedge clock);
    check("en_resume_start", txd, 0);
    wait_idle(200, 1'b1);

    // Reset asserted during data bit 3; the partial byte is lost.
    cyc();
    en = 1'b0;
    push(8'hC3);
    push(8'h96);
    cyc();
    cyc();
    en = 1'b1;
    wait_rdreq(10);
    repeat (9) @(posedge clock);
    #1;
    sclr = 1'b1;
    @(negedge clock);
    check("rst_mid_no_pop", bus.fifo_rdreq, 0);
    cyc();
    sclr = 1'b0;
    @(negedge clock);
    check("rst_mid_txd", txd, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_bytes_left", fq.size(), 1);
    wait_idle(200, 1'b1);

    repeat (3) cyc();
    check("scoreboard_drained", exp_q.size(), 0);
    check("total_pops", pop_cnt, 24);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
